wb_cache: RTL and testbench

Parametrised direct-mapped write-back, write-allocate cache sitting between the byte-wide processor data port and the line-wide backing memory. Each line carries a valid and dirty bit. Misses are handled by an explicit state machine with a req/ack handshake to memory: dirty victim write-back first, then line fill. Processor accesses stall (`cpu_ready` low) until the access completes.

---
 rtl/cache_pkg.sv | 25 ++
 rtl/cache_line_store.sv | 39 +++
 rtl/wb_cache.sv | 145 ++++++++++++++
 tb/tb_wb_cache.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared FSM encoding, width helpers and line-address assembly for the write-back cache.
package cache_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE      = 2'd0;
   localparam state_t COMPARE   = 2'd1;
   localparam state_t WRITEBACK = 2'd2;
   localparam state_t ALLOCATE  = 2'd3;

   function automatic int clog2(input int value);
      int r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Caller truncates the result to its own address width.
   function automatic logic [63:0] line_addr(input logic [63:0] tag, input logic [63:0] idx,
                                             input int idx_w, input int off_w);
      return ((tag << idx_w) | idx) << off_w;
   endfunction

endpackage

// File: rtl/cache_line_store.sv
// Line data + tag arrays; combinational read of the indexed line, writes land on the next clk edge.
// No backpressure: fill and byte-lane writes are mutually exclusive by construction in the caller.
module cache_line_store
   import cache_pkg::*;
#(
   parameter int  NUM_LINES  = 4,
   parameter int  LINE_BYTES = 128,
   parameter int  TAG_W      = 23,
   localparam int IDX_W      = clog2(NUM_LINES),
   localparam int OFF_W      = clog2(LINE_BYTES)
) (
   input  logic                    clk,
   input  logic [IDX_W-1:0]        idx,
   output logic [8*LINE_BYTES-1:0] rd_dat,
   output logic [TAG_W-1:0]        rd_tag,
   input  logic                    fill_vld,
   input  logic [TAG_W-1:0]        fill_tag,
   input  logic [8*LINE_BYTES-1:0] fill_dat,
   input  logic                    byte_vld,
   input  logic [OFF_W-1:0]        byte_off,
   input  logic [7:0]              byte_dat
);

   logic [8*LINE_BYTES-1:0] data_q [NUM_LINES];
   logic [TAG_W-1:0]        tag_q  [NUM_LINES];

   assign rd_dat = data_q[idx];
   assign rd_tag = tag_q[idx];

   always_ff @(posedge clk) begin
      if (fill_vld) begin
         data_q[idx] <= fill_dat;
         tag_q[idx]  <= fill_tag;
      end else if (byte_vld) begin
         data_q[idx][byte_off*8 +: 8] <= byte_dat;
      end
   end

endmodule

// File: rtl/wb_cache.sv
// Direct-mapped write-back/write-allocate byte cache: hit completes one cycle after request,
// misses stall cpu_ready while memory req/ack transactions (write-back then fill) run.
module wb_cache
   import cache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int LINE_BYTES = 128,
   parameter int NUM_LINES  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cpu_req,
   input  logic                    cpu_we,
   input  logic [ADDR_W-1:0]       cpu_addr,
   input  logic [7:0]              cpu_wdata,
   output logic [7:0]              cpu_rdata,
   output logic                    cpu_ready,
   output logic                    hit,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [8*LINE_BYTES-1:0] mem_wdata,
   input  logic [8*LINE_BYTES-1:0] mem_rdata,
   input  logic                    mem_ack
);

   localparam int OFF_W = clog2(LINE_BYTES);
   localparam int IDX_W = clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

   state_t                  state;
   logic                    req_we;
   logic [ADDR_W-1:0]       req_addr;
   logic [7:0]              req_wdata;
   logic                    missed;
   logic                    mem_req_q;
   logic [NUM_LINES-1:0]    valid;
   logic [NUM_LINES-1:0]    dirty;

   logic [IDX_W-1:0]        req_idx;
   logic [TAG_W-1:0]        req_tag;
   logic [OFF_W-1:0]        req_off;
   logic [8*LINE_BYTES-1:0] line_dat;
   logic [TAG_W-1:0]        line_tag;
   logic [TAG_W-1:0]        addr_tag;
   logic                    is_hit;
   logic                    fill_vld;
   logic                    byte_vld;

   assign req_idx = req_addr[OFF_W +: IDX_W];
   assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
   assign req_off = req_addr[OFF_W-1:0];
   assign is_hit  = valid[req_idx] && (line_tag == req_tag);

   assign fill_vld = (state == ALLOCATE) && mem_req_q && mem_ack;
   assign byte_vld = (state == COMPARE) && is_hit && req_we;

   cache_line_store #(
      .NUM_LINES (NUM_LINES),
      .LINE_BYTES(LINE_BYTES),
      .TAG_W     (TAG_W)
   ) u_store (
      .clk     (clk),
      .idx     (req_idx),
      .rd_dat  (line_dat),
      .rd_tag  (line_tag),
      .fill_vld(fill_vld),
      .fill_tag(req_tag),
      .fill_dat(mem_rdata),
      .byte_vld(byte_vld),
      .byte_off(req_off),
      .byte_dat(req_wdata)
   );

   // Memory-side outputs derive from registered state, so an async reset drops them at once.
   assign addr_tag  = (state == WRITEBACK) ? line_tag : req_tag;
   assign mem_req   = mem_req_q;
   assign mem_we    = (state == WRITEBACK);
   assign mem_wdata = line_dat;
   assign mem_addr  = (state == WRITEBACK || state == ALLOCATE)
                    ? ADDR_W'(line_addr(64'(addr_tag), 64'(req_idx), IDX_W, OFF_W))
                    : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         req_we    <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
         missed    <= 1'b0;
         mem_req_q <= 1'b0;
         valid     <= '0;
         dirty     <= '0;
         cpu_ready <= 1'b0;
         hit       <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         cpu_ready <= 1'b0;
         hit       <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  req_we    <= cpu_we;
                  req_addr  <= cpu_addr;
                  req_wdata <= cpu_wdata;
                  missed    <= 1'b0;
                  state     <= COMPARE;
               end
            end
            COMPARE: begin
               if (is_hit) begin
                  cpu_ready <= 1'b1;
                  hit       <= !missed;
                  if (req_we) dirty[req_idx] <= 1'b1;
                  else        cpu_rdata      <= line_dat[req_off*8 +: 8];
                  state <= IDLE;
               end else begin
                  missed    <= 1'b1;
                  mem_req_q <= 1'b1;
                  state     <= (valid[req_idx] && dirty[req_idx]) ? WRITEBACK : ALLOCATE;
               end
            end
            WRITEBACK: begin
               if (mem_ack) begin
                  mem_req_q <= 1'b0;
                  state     <= ALLOCATE;
               end
            end
            ALLOCATE: begin
               // Entered from WRITEBACK with mem_req low: re-raise after one idle cycle.
               if (!mem_req_q) begin
                  mem_req_q <= 1'b1;
               end else if (mem_ack) begin
                  mem_req_q      <= 1'b0;
                  valid[req_idx] <= 1'b1;
                  dirty[req_idx] <= 1'b0;
                  state          <= COMPARE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_cache.sv
// Directed checks on a default-sized cache plus randomised traffic on an 8x16B cache.
module tb_wb_cache;

   localparam int LB0 = 128;
   localparam int LB1 = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst0, req0, we0, rdy0, hit0, mreq0, mwe0, mack0;
   logic [31:0]       addr0, maddr0;
   logic [7:0]        wd0, rd0;
   logic [8*LB0-1:0]  mwd0, mrd0;

   logic              rst1, req1, we1, rdy1, hit1, mreq1, mwe1, mack1;
   logic [31:0]       addr1, maddr1;
   logic [7:0]        wd1, rd1;
   logic [8*LB1-1:0]  mwd1, mrd1;

   wb_cache #(.ADDR_W(32), .LINE_BYTES(LB0), .NUM_LINES(4)) d0 (
      .clk(clk), .rst(rst0), .cpu_req(req0), .cpu_we(we0), .cpu_addr(addr0),
      .cpu_wdata(wd0), .cpu_rdata(rd0), .cpu_ready(rdy0), .hit(hit0),
      .mem_req(mreq0), .mem_we(mwe0), .mem_addr(maddr0), .mem_wdata(mwd0),
      .mem_rdata(mrd0), .mem_ack(mack0));

   wb_cache #(.ADDR_W(32), .LINE_BYTES(LB1), .NUM_LINES(8)) d1 (
      .clk(clk), .rst(rst1), .cpu_req(req1), .cpu_we(we1), .cpu_addr(addr1),
      .cpu_wdata(wd1), .cpu_rdata(rd1), .cpu_ready(rdy1), .hit(hit1),
      .mem_req(mreq1), .mem_we(mwe1), .mem_addr(maddr1), .mem_wdata(mwd1),
      .mem_rdata(mrd1), .mem_ack(mack1));

   int checks = 0;
   int errors = 0;

   logic [7:0] mem0 [int unsigned];
   logic [7:0] mem1 [int unsigned];

   logic        t0_we   [$];
   logic [31:0] t0_addr [$];
   logic [7:0]  t0_b5   [$];
   int          t0_gap  [$];
   logic        hold0 = 1'b0;

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5C;
   endfunction

   function automatic logic [7:0] rd_mem0(input logic [31:0] a);
      return mem0.exists(a) ? mem0[a] : init_byte(a);
   endfunction

   function automatic logic [7:0] rd_mem1(input logic [31:0] a);
      return mem1.exists(a) ? mem1[a] : init_byte(a);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic t0_clear();
      t0_we.delete(); t0_addr.delete(); t0_b5.delete(); t0_gap.delete();
   endtask

   task automatic acc0(input logic w, input logic [31:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output logic h, output int n);
      bit done = 0;
      @(negedge clk); req0 = 1'b1; we0 = w; addr0 = a; wd0 = d;
      @(posedge clk); #1 req0 = 1'b0;
      n = 0; rd = 8'h00; h = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk); n++;
         if (rdy0) begin done = 1; rd = rd0; h = hit0; end
      end
      chk("d0 completion within budget", 64'(done), 64'd1);
   endtask

   task automatic acc1(input logic w, input logic [31:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output logic h, output int n);
      bit done = 0;
      @(negedge clk); req1 = 1'b1; we1 = w; addr1 = a; wd1 = d;
      @(posedge clk); #1 req1 = 1'b0;
      n = 0; rd = 8'h00; h = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk); n++;
         if (rdy1) begin done = 1; rd = rd1; h = hit1; end
      end
      chk("d1 completion within budget", 64'(done), 64'd1);
   endtask

   initial begin
      logic [7:0]  rd;
      logic        h, w, exp_hit, seen;
      logic [31:0] a;
      logic [7:0]  d;
      int          n;
      logic [7:0]  ref1 [512];
      int          res1 [8];

      rst0 = 1'b1; req0 = 1'b0; we0 = 1'b0; addr0 = '0; wd0 = '0; mack0 = 1'b0; mrd0 = '0;
      rst1 = 1'b1; req1 = 1'b0; we1 = 1'b0; addr1 = '0; wd1 = '0; mack1 = 1'b0; mrd1 = '0;

      // Memory responders: ack on the third sampled cycle of a request.
      fork
         begin : resp0
            int cnt = 0, low = 0;
            logic cwe; logic [31:0] cad; logic [8*LB0-1:0] cwd;
            forever begin
               @(negedge clk);
               if (rst0) begin mack0 = 1'b0; cnt = 0; end
               else if (hold0) cnt = 0;
               else begin
                  if (mack0) begin mack0 = 1'b0; cnt = 0; low = 0; end
                  if (mreq0) begin
                     if (cnt == 0) begin
                        cwe = mwe0; cad = maddr0; cwd = mwd0; t0_gap.push_back(low);
                     end else begin
                        chk("d0 mem_addr stable", 64'(maddr0), 64'(cad));
                        chk("d0 mem_we stable", 64'(mwe0), 64'(cwe));
                        chk("d0 mem_wdata stable", 64'(mwd0 === cwd), 64'd1);
                     end
                     cnt++;
                     if (cnt == 3) begin
                        mack0 = 1'b1;
                        t0_we.push_back(mwe0); t0_addr.push_back(maddr0); t0_b5.push_back(mwd0[47:40]);
                        for (int i = 0; i < LB0; i++) begin
                           if (mwe0) mem0[maddr0 + i] = mwd0[8*i +: 8];
                           else      mrd0[8*i +: 8] = rd_mem0(maddr0 + i);
                        end
                     end
                  end else low++;
               end
            end
         end
         begin : resp1
            int cnt = 0;
            forever begin
               @(negedge clk);
               if (rst1) begin mack1 = 1'b0; cnt = 0; end
               else begin
                  if (mack1) begin mack1 = 1'b0; cnt = 0; end
                  if (mreq1) begin
                     cnt++;
                     if (cnt == 3) begin
                        mack1 = 1'b1;
                        for (int i = 0; i < LB1; i++) begin
                           if (mwe1) mem1[maddr1 + i] = mwd1[8*i +: 8];
                           else      mrd1[8*i +: 8] = rd_mem1(maddr1 + i);
                        end
                     end
                  end
               end
            end
         end
      join_none

      repeat (3) @(negedge clk);
      chk("reset cpu_ready", 64'(rdy0), 64'd0);
      chk("reset hit", 64'(hit0), 64'd0);
      chk("reset mem_req", 64'(mreq0), 64'd0);
      chk("reset mem_we", 64'(mwe0), 64'd0);
      chk("reset cpu_rdata", 64'(rd0), 64'd0);
      chk("reset mem_addr", 64'(maddr0), 64'd0);
      chk("reset d1 mem_req", 64'(mreq1), 64'd0);
      rst0 = 1'b0; rst1 = 1'b0;

      // Cold read miss: single fill, then a repeat read hits in 2 cycles.
      t0_clear(); acc0(1'b0, 32'h1005, 8'h00, rd, h, n);
      chk("cold miss txn count", 64'(t0_we.size()), 64'd1);
      chk("cold miss mem_we", 64'(t0_we[0]), 64'd0);
      chk("cold miss mem_addr", 64'(t0_addr[0]), 64'h1000);
      chk("cold miss hit", 64'(h), 64'd0);
      chk("cold miss rdata", 64'(rd), 64'(init_byte(32'h1005)));

      t0_clear(); acc0(1'b0, 32'h1005, 8'h00, rd, h, n);
      chk("read hit latency", 64'(n), 64'd2);
      chk("read hit flag", 64'(h), 64'd1);
      chk("read hit no txn", 64'(t0_we.size()), 64'd0);
      chk("read hit rdata", 64'(rd), 64'(init_byte(32'h1005)));

      t0_clear(); acc0(1'b1, 32'h1005, 8'hA5, rd, h, n);
      chk("write hit flag", 64'(h), 64'd1);
      chk("write hit no txn", 64'(t0_we.size()), 64'd0);

      // Dirty conflict: write-back of 0x1000 with 0xA5, one idle cycle, fill of 0x2000.
      t0_clear(); acc0(1'b0, 32'h2005, 8'h00, rd, h, n);
      chk("dirty miss txn count", 64'(t0_we.size()), 64'd2);
      chk("writeback mem_we", 64'(t0_we[0]), 64'd1);
      chk("writeback mem_addr", 64'(t0_addr[0]), 64'h1000);
      chk("writeback byte5", 64'(t0_b5[0]), 64'hA5);
      chk("fill after wb mem_we", 64'(t0_we[1]), 64'd0);
      chk("fill after wb mem_addr", 64'(t0_addr[1]), 64'h2000);
      chk("wb-to-fill idle cycles", 64'(t0_gap[1]), 64'd1);
      chk("dirty miss hit", 64'(h), 64'd0);
      chk("dirty miss rdata", 64'(rd), 64'(init_byte(32'h2005)));

      // Clean conflict: fill only, and the written-back byte comes home.
      t0_clear(); acc0(1'b0, 32'h1005, 8'h00, rd, h, n);
      chk("clean conflict txn count", 64'(t0_we.size()), 64'd1);
      chk("clean conflict mem_we", 64'(t0_we[0]), 64'd0);
      chk("clean conflict mem_addr", 64'(t0_addr[0]), 64'h1000);
      chk("clean conflict rdata", 64'(rd), 64'hA5);

      // Write miss allocates then merges.
      t0_clear(); acc0(1'b1, 32'h3081, 8'h5A, rd, h, n);
      chk("write miss txn count", 64'(t0_we.size()), 64'd1);
      chk("write miss fill addr", 64'(t0_addr[0]), 64'h3080);
      chk("write miss hit", 64'(h), 64'd0);
      t0_clear(); acc0(1'b0, 32'h3081, 8'h00, rd, h, n);
      chk("read after write miss rdata", 64'(rd), 64'h5A);
      chk("read after write miss hit", 64'(h), 64'd1);
      chk("read after write miss no txn", 64'(t0_we.size()), 64'd0);

      // Reset in the middle of a fill.
      hold0 = 1'b1; t0_clear();
      @(negedge clk); req0 = 1'b1; we0 = 1'b0; addr0 = 32'h1100;
      @(posedge clk); #1 req0 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (mreq0) seen = 1'b1;
      end
      chk("held fill requested", 64'(seen), 64'd1);
      chk("held fill mem_addr", 64'(maddr0), 64'h1100);
      @(posedge clk); #2 rst0 = 1'b1;
      #1 chk("mem_req async drop", 64'(mreq0), 64'd0);
      @(negedge clk); rst0 = 1'b0;
      @(negedge clk); mack0 = 1'b1;
      @(negedge clk); mack0 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("late ack ignored mem_req", 64'(mreq0), 64'd0);
         chk("late ack ignored cpu_ready", 64'(rdy0), 64'd0);
      end
      hold0 = 1'b0;
      t0_clear(); acc0(1'b0, 32'h3081, 8'h00, rd, h, n);
      chk("post-reset miss hit", 64'(h), 64'd0);
      chk("post-reset miss txn count", 64'(t0_we.size()), 64'd1);
      chk("post-reset lost dirty byte", 64'(rd), 64'(init_byte(32'h3081)));
      t0_clear(); acc0(1'b0, 32'h1005, 8'h00, rd, h, n);
      chk("post-reset idx0 miss", 64'(h), 64'd0);
      chk("post-reset idx0 rdata", 64'(rd), 64'hA5);

      // Randomised traffic on the 8-line, 16-byte cache against a flat byte memory.
      for (int i = 0; i < 512; i++) ref1[i] = init_byte(32'(i));
      for (int i = 0; i < 8; i++) res1[i] = -1;
      for (int k = 0; k < 300; k++) begin
         w = 1'($urandom_range(0, 1));
         a = 32'($urandom_range(0, 511));
         d = 8'($urandom_range(0, 255));
         acc1(w, a, d, rd, h, n);
         exp_hit = (res1[(a / LB1) % 8] == int'(a / LB1));
         chk("rnd hit", 64'(h), 64'(exp_hit));
         if (exp_hit) chk("rnd hit latency", 64'(n), 64'd2);
         if (w) ref1[a] = d;
         else   chk("rnd rdata", 64'(rd), 64'(ref1[a]));
         res1[(a / LB1) % 8] = int'(a / LB1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
